// File: rtl/cnt_random_seq.sv
// -----------------------------------------------------------------------------
// cnt_random_seq
//   Steps a 3-bit LED code through a fixed, scrambled-looking 8-entry cycle:
//     0 -> 5 -> 2 -> 7 -> 1 -> 4 -> 6 -> 3 -> 0 -> ...
//   Every code appears exactly once per 8-step period. A clock divider lets the
//   sequence advance once every DIV clock cycles.
//
// Parameters
//   DIV    : clk cycles per sequence step, legal range 1..65535 (default 1).
//
// Ports
//   clk    : input,  rising-edge clock; all state changes on the rising edge.
//   reset  : input,  synchronous active-high reset; forces led=0, divider=0.
//   led    : output, [2:0] current sequence value, driven straight from a flop.
//
// Build option
//   CNT_RANDOM_SEQ_ONEHOT_EN : when defined, the sequence position is held in an
//   8-bit one-hot register and led is a registered decode of that position.
//   Any non-one-hot pattern is pulled back to position 0 (led=0) on the next
//   edge. When undefined, led itself is the 3-bit binary state with a
//   next-state case table. Both builds produce identical led timing/values.
//
// Power-up: all flops carry a declaration initial value so led is 0 (never X)
// even before the first clock edge.
// -----------------------------------------------------------------------------
module cnt_random_seq #(
  parameter int unsigned DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] led
);

  // Divider width: ceil(log2(DIV)), at least one bit. DIV-1 always fits.
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  // ---------------------------------------------------------------------------
  // Step divider: counts 0..DIV-1; the sequence advances on the edge where the
  // count is DIV-1, and the count wraps to 0 on that same edge. With DIV=1 the
  // count is stuck at 0 and every edge is a step.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q = '0;
  logic [DIV_W-1:0] div_d;
  logic             step;

  always_comb begin
    step  = (div_q == DIV_LAST);
    div_d = step ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  // led is always the output of this flop in both builds.
  logic [2:0] led_q = 3'd0;
  logic [2:0] led_d;

`ifdef CNT_RANDOM_SEQ_ONEHOT_EN
  // ---------------------------------------------------------------------------
  // One-hot position register: bit i set means sequence position i.
  // Position 0 (led=0) is 8'h01. A step rotates the hot bit left by one.
  // ---------------------------------------------------------------------------
  logic [7:0] onehot_q = 8'h01;
  logic [7:0] onehot_d;
  logic       onehot_ok;

  always_comb begin
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    onehot_ok = (onehot_q != 8'h00) && ((onehot_q & (onehot_q - 8'h01)) == 8'h00);

    if (!onehot_ok)  onehot_d = 8'h01;
    else if (step)   onehot_d = {onehot_q[6:0], onehot_q[7]};
    else             onehot_d = onehot_q;

    // Decode the next position so led updates on the same edge as the
    // position register, matching the binary build cycle for cycle.
    led_d = 3'd0;
    case (onehot_d)
      8'h01:   led_d = 3'd0;
      8'h02:   led_d = 3'd5;
      8'h04:   led_d = 3'd2;
      8'h08:   led_d = 3'd7;
      8'h10:   led_d = 3'd1;
      8'h20:   led_d = 3'd4;
      8'h40:   led_d = 3'd6;
      8'h80:   led_d = 3'd3;
      default: led_d = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      onehot_q <= 8'h01;
      led_q    <= 3'd0;
    end else begin
      onehot_q <= onehot_d;
      led_q    <= led_d;
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Binary build: the led code is the state; the case table is the sequence.
  // ---------------------------------------------------------------------------
  always_comb begin
    led_d = led_q;
    if (step) begin
      case (led_q)
        3'd0: led_d = 3'd5;
        3'd5: led_d = 3'd2;
        3'd2: led_d = 3'd7;
        3'd7: led_d = 3'd1;
        3'd1: led_d = 3'd4;
        3'd4: led_d = 3'd6;
        3'd6: led_d = 3'd3;
        3'd3: led_d = 3'd0;
        default: led_d = 3'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) led_q <= 3'd0;
    else       led_q <= led_d;
  end
`endif

  assign led = led_q;

endmodule

// File: tb/tb_cnt_random_seq.sv
// -----------------------------------------------------------------------------
// tb_cnt_random_seq
//   Directed bench for cnt_random_seq. Two instances share one clock:
//     dut_a : DIV=1, own reset rst_a
//     dut_b : DIV=3, own reset rst_b
//   Inputs are driven on the falling edge; outputs are sampled 1 ns after the
//   rising edge.
// -----------------------------------------------------------------------------
module tb_cnt_random_seq;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk   = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [2:0] led_a;
  logic [2:0] led_b;

  always #5 clk = ~clk;

  cnt_random_seq #(.DIV(1)) dut_a (.clk(clk), .reset(rst_a), .led(led_a));
  cnt_random_seq #(.DIV(3)) dut_b (.clk(clk), .reset(rst_b), .led(led_b));

  // ---------------------------------------------------------------------------
  // Scoreboard counters and the single checking task
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_resets(input logic a, input logic b);
    @(negedge clk);
    rst_a = a;
    rst_b = b;
  endtask

  // Reference sequence (hand-written from the required cycle)
  logic [2:0] seq_tab [8] = '{3'd0, 3'd5, 3'd2, 3'd7, 3'd1, 3'd4, 3'd6, 3'd3};

  // Expected led_a after each of the first 9 edges (DIV=1)
  logic [2:0] exp_s1 [9] = '{3'd5, 3'd2, 3'd7, 3'd1, 3'd4, 3'd6, 3'd3, 3'd0, 3'd5};
  // Expected led_b after each of the first 9 edges (DIV=3)
  logic [2:0] exp_s3 [9] = '{3'd0, 3'd0, 3'd5, 3'd5, 3'd5, 3'd2, 3'd2, 3'd2, 3'd7};

  int counts [8];
  int p;
  bit found;

  // ---------------------------------------------------------------------------
  // Timeout guard
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Main stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Scenario 1 / 3: reset high for 1 ns only; no clock edge occurs in it,
    // so the power-up values must already be 0.
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    check("powerup_a", {29'd0, led_a}, 32'd0);
    check("powerup_b", {29'd0, led_b}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("s1_a_edge%0d", i + 1), {29'd0, led_a}, {29'd0, exp_s1[i]});
      check($sformatf("s3_b_edge%0d", i + 1), {29'd0, led_b}, {29'd0, exp_s3[i]});
    end

    // Scenario 2: run to led_a==7 (bounded), then reset for 100 ns.
    // dut_b is mid-divide at that point as well.
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      tick();
      if (led_a == 3'd7) found = 1'b1;
    end
    check("s2_reach_7", {31'd0, found}, 32'd1);

    drive_resets(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("s2_rst_a_%0d", i), {29'd0, led_a}, 32'd0);
      check($sformatf("s2_rst_b_%0d", i), {29'd0, led_b}, 32'd0);
    end
    drive_resets(1'b0, 1'b0);
    tick();
    check("s2_rel_a1", {29'd0, led_a}, 32'd5);
    check("s2_rel_b1", {29'd0, led_b}, 32'd0);
    tick();
    check("s2_rel_a2", {29'd0, led_a}, 32'd2);
    check("s2_rel_b2", {29'd0, led_b}, 32'd0);
    tick();
    check("s2_rel_a3", {29'd0, led_a}, 32'd7);
    check("s2_rel_b3", {29'd0, led_b}, 32'd5);

    // Scenario 4: one reset edge, then 64 edges -> 8 full periods.
    drive_resets(1'b1, 1'b0);
    tick();
    check("s4_start", {29'd0, led_a}, 32'd0);
    drive_resets(1'b0, 1'b0);
    for (int c = 0; c < 8; c++) counts[c] = 0;
    p = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      p = (p + 1) % 8;
      check($sformatf("s4_step%0d", i), {29'd0, led_a}, {29'd0, seq_tab[p]});
      if (!$isunknown(led_a)) counts[led_a] = counts[led_a] + 1;
    end
    for (int c = 0; c < 8; c++)
      check($sformatf("s4_count_code%0d", c), counts[c], 32'd8);

`ifdef CNT_RANDOM_SEQ_ONEHOT_EN
    // Scenario 5: illegal one-hot pattern recovers to position 0.
    @(negedge clk);
    force dut_a.onehot_q = 8'b0000_0011;
    #1;
    release dut_a.onehot_q;
    tick();
    check("s5_recover", {29'd0, led_a}, 32'd0);
    tick();
    check("s5_resume", {29'd0, led_a}, 32'd5);
`endif

    // Scenario 6: 200 cycles with a fixed pattern of reset pulses against the
    // reference model (identical expectations hold for both builds).
    drive_resets(1'b1, 1'b0);
    tick();
    p = 0;
    for (int i = 0; i < 200; i++) begin
      drive_resets(((i % 23) == 7) || ((i % 41) == 0), 1'b0);
      tick();
      if (rst_a) p = 0;
      else       p = (p + 1) % 8;
      check($sformatf("s6_cycle%0d", i), {29'd0, led_a}, {29'd0, seq_tab[p]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
